// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache/memory models: FSM encodings, default widths
// and the reset fill pattern (word i holds i) used by every level of the hierarchy.
package cache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  // Wide enough for any data width in use; callers truncate or zero-extend by cast.
  function automatic logic [63:0] mem_init_word(input int unsigned idx);
    return 64'(idx);
  endfunction

endpackage

// File: rtl/latency_timer.sv
// Load/decrement countdown timer; done_o is high whenever the count is zero.
// Load takes priority over decrement; decrement stops at zero.
module latency_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/main_memory_responder.sv
// Backing store below L2: one request at a time, response pulse LATENCY cycles after accept.
// req_ready is low from accept until the cycle after the response; the response cannot be stalled.
module main_memory_responder
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              report,
  output logic [CNT_W-1:0]  read_count,
  output logic [CNT_W-1:0]  write_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [TW-1:0]    LOAD_VAL = TW'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e state_q, state_d;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_out_q, wr_out_q;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic accept;
  logic tmr_load;
  logic tmr_dec;
  logic tmr_done;
  logic commit;

  latency_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (tmr_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) && !rst;
    tmr_load  = accept;
    tmr_dec   = (state_q == BUSY);
    commit    = (state_q == BUSY) && tmr_done;
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (accept && !req_write && (rd_cnt_q != CNT_MAX)) rd_cnt_d = rd_cnt_q + 1'b1;
    if (accept && req_write && (wr_cnt_q != CNT_MAX))  wr_cnt_d = wr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      rd_out_q     <= '0;
      wr_out_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(mem_init_word(i));
      end
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      resp_valid_q <= commit;
      // The write lands on the same edge as the ack, so a following read sees it.
      if (commit) begin
        if (wr_q) begin
          mem[addr_q]  <= wdata_q;
          resp_rdata_q <= wdata_q;
        end else begin
          resp_rdata_q <= mem[addr_q];
        end
      end
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      if (!report) begin
        rd_out_q <= rd_cnt_d;
        wr_out_q <= wr_cnt_d;
      end
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign read_count  = rd_out_q;
  assign write_count = wr_out_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench with a response scoreboard for main_memory_responder (LATENCY=4).
// A narrow-counter second instance shares the stimulus to exercise counter saturation.
module tb_main_memory_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        report = 1'b0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [15:0] read_count;
  logic [15:0] write_count;

  logic        sat_req_ready;
  logic        sat_resp_valid;
  logic [31:0] sat_resp_rdata;
  logic [1:0]  sat_read_count;
  logic [1:0]  sat_write_count;

  int n_cmp = 0;
  int n_err = 0;
  int edge_no = 0;

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    int          due;
  } txn_t;

  txn_t        sb_q[$];
  logic [31:0] model_mem [0:255];

  always #5 clk = ~clk;

  main_memory_responder #(
    .ADDR_W (8), .DATA_W (32), .LATENCY (LAT), .CNT_W (16)
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
    .req_addr (req_addr), .req_wdata (req_wdata),
    .resp_valid (resp_valid), .resp_rdata (resp_rdata),
    .report (report), .read_count (read_count), .write_count (write_count)
  );

  main_memory_responder #(
    .ADDR_W (8), .DATA_W (32), .LATENCY (LAT), .CNT_W (2)
  ) dut_sat (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (sat_req_ready), .req_write (req_write),
    .req_addr (req_addr), .req_wdata (req_wdata),
    .resp_valid (sat_resp_valid), .resp_rdata (sat_resp_rdata),
    .report (report), .read_count (sat_read_count), .write_count (sat_write_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: record accepts at the edge, check responses #1 after it.
  always @(posedge clk) begin
    txn_t t;
    logic [31:0] exp;
    edge_no++;
    if (rst) begin
      sb_q.delete();
      for (int i = 0; i < 256; i++) model_mem[i] = i;
    end else if (req_valid && req_ready) begin
      sb_q.push_back('{w: req_write, a: req_addr, d: req_wdata, due: edge_no + LAT});
    end
    #1;
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        check("resp_unexpected", resp_valid, 1'b0);
      end else begin
        t = sb_q.pop_front();
        check("resp_latency", edge_no, t.due);
        exp = t.w ? t.d : model_mem[t.a];
        if (t.w) model_mem[t.a] = t.d;
        check("resp_rdata", resp_rdata, exp);
      end
    end else if (sb_q.size() > 0 && edge_no >= sb_q[0].due) begin
      check("resp_missing", resp_valid, 1'b1);
      void'(sb_q.pop_front());
    end
  end

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input bit hold, output int acc);
    acc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int k = 0; k < 20; k++) begin
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc = edge_no;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check("accept_timeout", req_ready, 1'b1);
    if (!hold) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30; k++) begin
      if (sb_q.size() == 0 && req_ready) break;
      @(negedge clk);
    end
    check("drain_timeout", sb_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2;

    // Reset held for 5 cycles.
    repeat (5) begin
      @(posedge clk);
      #1;
      check("rst_ready", req_ready, 1'b0);
    end
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_read_count", read_count, 16'h0);
    check("rst_write_count", write_count, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1'b1);

    // Single read: exact latency and ready window.
    issue(1'b0, 8'h20, 32'h0, 1'b0, a0);
    check("busy_ready_t0", req_ready, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check("ready_window", req_ready, (k == 5) ? 1'b1 : 1'b0);
      check("resp_pulse", resp_valid, (k == LAT) ? 1'b1 : 1'b0);
    end
    check("rdata_hold", resp_rdata, 32'h0000_0020);

    // Write then read the same address.
    issue(1'b1, 8'h28, 32'h00ab_cdef, 1'b0, a0);
    wait_idle();
    issue(1'b0, 8'h28, 32'h0, 1'b0, a0);
    wait_idle();
    check("raw_rdata", resp_rdata, 32'h00ab_cdef);
    check("wcnt_after_raw", write_count, 16'd1);
    check("rcnt_after_raw", read_count, 16'd2);

    // Valid held high with changing inputs during BUSY must not be accepted.
    issue(1'b0, 8'h40, 32'h0, 1'b1, a0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_addr = 8'h50 + 8'(k);
      req_write = 1'b1;
      req_wdata = $urandom;
    end
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    check("rdata_held_inputs", resp_rdata, 32'h0000_0040);
    check("rcnt_held", read_count, 16'd3);
    check("wcnt_held", write_count, 16'd1);

    // Back-to-back reads with valid held: accepts 6 cycles apart.
    issue(1'b0, 8'h18, 32'h0, 1'b1, a1);
    issue(1'b0, 8'h30, 32'h0, 1'b0, a2);
    check("b2b_spacing", a2 - a1, LAT + 2);
    wait_idle();
    check("b2b_last_rdata", resp_rdata, 32'h0000_0030);
    check("rcnt_b2b", read_count, 16'd5);

    // Reset during BUSY of a write aborts it.
    issue(1'b1, 8'h10, 32'hdead_beef, 1'b0, a0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort_resp_valid", resp_valid, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_rcnt", read_count, 16'd0);
    check("abort_wcnt", write_count, 16'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("abort_no_resp", resp_valid, 1'b0);
    end
    issue(1'b0, 8'h10, 32'h0, 1'b0, a0);
    wait_idle();
    check("abort_reinit_10", resp_rdata, 32'h0000_0010);
    issue(1'b0, 8'h28, 32'h0, 1'b0, a0);
    wait_idle();
    check("abort_reinit_28", resp_rdata, 32'h0000_0028);

    // Saturation on the narrow-counter instance.
    issue(1'b0, 8'h20, 32'h0, 1'b0, a0);
    wait_idle();
    check("sat_reach", sat_read_count, 2'd3);
    issue(1'b0, 8'h21, 32'h0, 1'b0, a0);
    wait_idle();
    issue(1'b0, 8'h22, 32'h0, 1'b0, a0);
    wait_idle();
    check("sat_hold", sat_read_count, 2'd3);
    check("sat_wcnt", sat_write_count, 2'd0);
    check("wide_rcnt", read_count, 16'd5);
    check("sat_same_rdata", sat_resp_rdata, resp_rdata);
    check("sat_same_ready", sat_req_ready, req_ready);
    check("sat_same_valid", sat_resp_valid, resp_valid);

    // Report freezes the counter outputs; they catch up after release.
    @(negedge clk);
    report = 1'b1;
    issue(1'b0, 8'h44, 32'h0, 1'b0, a0);
    wait_idle();
    check("report_frozen", read_count, 16'd5);
    check("report_rdata", resp_rdata, 32'h0000_0044);
    report = 1'b0;
    #1;
    check("report_before_edge", read_count, 16'd5);
    @(posedge clk);
    #1;
    check("report_released", read_count, 16'd6);
    check("report_wcnt", write_count, 16'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
